tdm_demux4: RTL and testbench
=============================

Name: tdm_demux4

Overview:
- Receive end of the 4:1 selector link: recovers four parallel bits from a time-division serial stream (one bit per slot, slot order 0..N-1).
- A frame-start strobe marks slot 0; a slot counter steers each sample into a staging register.
- A completed frame is published atomically to the parallel outputs (board LEDs), with a one-cycle valid pulse.

Parameters:
SLOTS, 4, slots per frame and output width; power of two, 2..16
SEL_W, 2, slot counter width, equal to clog2(SLOTS)

Ports:
clk  input  1  system clock, all logic on the rising edge
rst  input  1  synchronous, active-high reset
en  input  1  sample enable; din and sync are sampled only on cycles with en=1
din  input  1  serial data, one slot per enabled cycle
sync  input  1  frame start; qualifies din as slot 0
w  output  SLOTS  last complete frame; w[k] holds slot k
s  output  SEL_W  slot index expected on the next enabled cycle
valid  output  1  one-cycle pulse when w updates
err  output  1  sticky framing/parity error flag

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Reset values: w=0, s=0, valid=0, err=0, staging register=0, state=IDLE. Reset mid-frame discards the partial frame.
- State IDLE:
  - Waits for an enabled cycle with sync=1.
  - On that cycle, stage[0]<=din, s<=1, go to RUN.
  - Enabled cycles with sync=0 are ignored; s stays 0.
- State RUN:
  - Each enabled cycle, stage[s]<=din and s<=s+1.
  - On the cycle that captures slot SLOTS-1, the next edge performs all of: w<={din, stage[SLOTS-2:0]}, valid=1 for exactly one cycle, s<=0, return to IDLE.
  - Latency: w and valid are visible the cycle after the last slot is sampled.
- en=0 cycles: state, s and stage hold; sync and din are ignored; valid stays 0. A frame may be spread across arbitrary gaps.
- sync=1 in RUN (premature frame start):
  - err<=1.
  - The partial frame is discarded with no w update and no valid pulse.
  - That cycle is treated as a new slot 0: stage[0]<=din, s<=1, stay in RUN.
- sync=1 coinciding with slot SLOTS-1 in RUN follows the same premature-start rule; the completed frame is not published.
- err clears only on rst.
- Bits of w are never updated individually; a single-edge update is the only path to w.
- s wraps from SLOTS-1 back to 0 only through completion or IDLE; no other wrap exists.

Optional Feature:
- Macro: TDM_DEMUX_PARITY_EN.
- When defined:
  - The frame carries one extra even-parity slot after slot SLOTS-1; s counts to SLOTS.
  - On the parity slot, if XOR(stage, din)=0, publish w and pulse valid.
  - Otherwise set err, leave w unchanged, give no valid pulse, and return to IDLE.
  - A sync during the parity slot follows the premature-start rule.
- When undefined: frame length is exactly SLOTS and no parity is checked.

Test Plan:
- Reset, then en=1 with din stream 1,0,1,1 and sync=1 on the first bit only -> w=4'b1101 one cycle after the 4th bit; valid high exactly one cycle; err=0.
- Same frame with en=0 for 3 cycles between slots 1 and 2 -> w=4'b1101; valid pulses once; s holds at 2 during the gap.
- Frame 1,1 then sync=1 with din 0, then 0,1,1 -> err=1; w=4'b1100 (the earlier w is never overwritten by the partial frame); exactly one valid pulse.
- Assert rst after slot 2 of a frame -> next cycle w=0, s=0, err=0; following idle cycles with sync=0 produce no valid.
- Back-to-back frames 0001 then 1010 with sync on each slot 0 -> w=4'b1000, then 4'b0101; two valid pulses four cycles apart.
- With TDM_DEMUX_PARITY_EN: bits 1,0,1,1 plus parity 1 -> w=4'b1101 with valid. Parity 0 -> err=1, w unchanged, no valid.

Source files
------------

// File: rtl/tdm_demux4.sv
// tdm_demux4: TDM serial-to-parallel receiver, one bit per slot, sync marks slot 0.
// Optional macro TDM_DEMUX_PARITY_EN appends an even-parity slot to each frame.
module tdm_demux4 #(
    parameter int SLOTS = 4,
    parameter int SEL_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             din,
    input  logic             sync,
    output logic [SLOTS-1:0] w,
    output logic [SEL_W-1:0] s,
    output logic             valid,
    output logic             err
);

`ifdef TDM_DEMUX_PARITY_EN
    // Counter needs one extra bit to reach the parity slot index SLOTS.
    localparam int CW   = SEL_W + 1;
    localparam int LAST = SLOTS;
`else
    localparam int CW   = SEL_W;
    localparam int LAST = SLOTS - 1;
`endif

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [SLOTS-1:0] stage;

    // s exposes the slot counter; on the parity slot it reads back as 0.
    assign s = cnt[SEL_W-1:0];

    // Frame capture FSM: stage slots, publish w atomically on completion.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            stage <= '0;
            w     <= '0;
            valid <= 1'b0;
            err   <= 1'b0;
        end else begin
            valid <= 1'b0;
            if (en) begin
                if (sync) begin
                    // Sync always restarts at slot 0; inside a frame it is a framing error.
                    if (state == RUN) begin
                        err <= 1'b1;
                    end
                    stage[0] <= din;
                    cnt      <= CW'(1);
                    state    <= RUN;
                end else if (state == RUN) begin
                    if (cnt == CW'(LAST)) begin
`ifdef TDM_DEMUX_PARITY_EN
                        if (^{stage, din} == 1'b0) begin
                            w     <= stage;
                            valid <= 1'b1;
                        end else begin
                            err <= 1'b1;
                        end
`else
                        w     <= {din, stage[SLOTS-2:0]};
                        valid <= 1'b1;
`endif
                        cnt   <= '0;
                        state <= IDLE;
                    end else begin
                        stage[cnt[SEL_W-1:0]] <= din;
                        cnt                   <= cnt + CW'(1);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_tdm_demux4.sv
// tb_tdm_demux4: random and directed stimulus against a queue-based frame model.
// Build with +define+TDM_DEMUX_PARITY_EN to exercise the parity variant.
module tb_tdm_demux4;

    localparam int SLOTS = 4;
    localparam int SEL_W = 2;
`ifdef TDM_DEMUX_PARITY_EN
    localparam int FL = SLOTS + 1;
`else
    localparam int FL = SLOTS;
`endif

    logic             clk = 1'b0;
    logic             rst, en, din, sync;
    logic [SLOTS-1:0] w;
    logic [SEL_W-1:0] s;
    logic             valid, err;

    int npass = 0;
    int ntot  = 0;

    bit               q[$];
    logic [SLOTS-1:0] ew;
    logic             ev, ee;
    int               nvalid;

    tdm_demux4 #(.SLOTS(SLOTS), .SEL_W(SEL_W)) dut (
        .clk(clk), .rst(rst), .en(en), .din(din), .sync(sync),
        .w(w), .s(s), .valid(valid), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        ntot++;
        if (got === exp) npass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    // Reference: collected bits of the current frame live in q.
    task automatic model(input logic r, input logic e, input logic sy,
                         input logic d);
        bit par;
        ev = 1'b0;
        if (r) begin
            q.delete();
            ew = '0;
            ee = 1'b0;
        end else if (e) begin
            if (sy) begin
                if (q.size() > 0) ee = 1'b1;
                q.delete();
                q.push_back(d);
            end else if (q.size() > 0) begin
                q.push_back(d);
            end
            if (q.size() == FL) begin
                par = 1'b0;
                foreach (q[i]) par ^= q[i];
                if (FL == SLOTS || par == 1'b0) begin
                    for (int k = 0; k < SLOTS; k++) ew[k] = q[k];
                    ev = 1'b1;
                end else begin
                    ee = 1'b1;
                end
                q.delete();
            end
        end
    endtask

    task automatic cyc(input logic r, input logic e, input logic sy,
                       input logic d);
        rst = r; en = e; sync = sy; din = d;
        @(posedge clk);
        model(r, e, sy, d);
        #1;
        if (valid) nvalid++;
        check("w", 32'(w), 32'(ew));
        check("s", 32'(s), 32'(q.size() % (1 << SEL_W)));
        check("valid", 32'(valid), 32'(ev));
        check("err", 32'(err), 32'(ee));
    endtask

    task automatic frame(input logic [SLOTS-1:0] b);
        for (int k = 0; k < SLOTS; k++) cyc(1'b0, 1'b1, k == 0, b[k]);
`ifdef TDM_DEMUX_PARITY_EN
        cyc(1'b0, 1'b1, 1'b0, ^b);
`endif
    endtask

    initial begin
        ew = '0; ev = 1'b0; ee = 1'b0; nvalid = 0;
        rst = 1'b1; en = 1'b0; sync = 1'b0; din = 1'b0;
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        check("rst_w", 32'(w), 32'h0);
        check("rst_s", 32'(s), 32'h0);

        // Frame 1,0,1,1 (slot 0 first) -> 4'b1101.
        nvalid = 0;
        frame(4'b1101);
        check("tp1_w", 32'(w), 32'hD);
        cyc(1'b0, 1'b1, 1'b0, 1'b1);
        check("tp1_once", 32'(nvalid), 32'd1);

        // Same frame with a 3-cycle en gap between slots 1 and 2.
        nvalid = 0;
        cyc(1'b0, 1'b1, 1'b1, 1'b1);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        repeat (3) begin
            cyc(1'b0, 1'b0, 1'b1, 1'b1);
            check("gap_s", 32'(s), 32'd2);
        end
        cyc(1'b0, 1'b1, 1'b0, 1'b1);
        cyc(1'b0, 1'b1, 1'b0, 1'b1);
`ifdef TDM_DEMUX_PARITY_EN
        cyc(1'b0, 1'b1, 1'b0, 1'b1);
`endif
        check("gap_w", 32'(w), 32'hD);
        check("gap_once", 32'(nvalid), 32'd1);

        // Premature sync: 1,1 then sync with 0,0,1,1.
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        nvalid = 0;
        cyc(1'b0, 1'b1, 1'b1, 1'b1);
        cyc(1'b0, 1'b1, 1'b0, 1'b1);
        frame(4'b1100);
        check("pre_err", 32'(err), 32'd1);
        check("pre_w", 32'(w), 32'hC);
        check("pre_once", 32'(nvalid), 32'd1);

        // Reset mid-frame, then idle cycles without sync.
        nvalid = 0;
        cyc(1'b0, 1'b1, 1'b1, 1'b1);
        cyc(1'b0, 1'b1, 1'b0, 1'b1);
        cyc(1'b0, 1'b1, 1'b0, 1'b1);
        cyc(1'b1, 1'b1, 1'b0, 1'b1);
        check("mid_w", 32'(w), 32'h0);
        check("mid_err", 32'(err), 32'h0);
        repeat (6) cyc(1'b0, 1'b1, 1'b0, 1'b1);
        check("mid_novalid", 32'(nvalid), 32'd0);

        // Back-to-back frames 0001 and 1010 in slot order.
        frame(4'b1000);
        check("b2b_w0", 32'(w), 32'h8);
        frame(4'b0101);
        check("b2b_w1", 32'(w), 32'h5);

`ifdef TDM_DEMUX_PARITY_EN
        // Bad parity: err set, w unchanged, no valid.
        nvalid = 0;
        for (int k = 0; k < SLOTS; k++)
            cyc(1'b0, 1'b1, k == 0, k != 1);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        check("par_err", 32'(err), 32'd1);
        check("par_w", 32'(w), 32'h5);
        check("par_novalid", 32'(nvalid), 32'd0);
`endif

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            cyc($urandom_range(0, 199) == 0, $urandom_range(0, 3) != 0,
                $urandom_range(0, 5) == 0, 1'($urandom));
        end

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
